// File: rtl/ad_frame_pkg.sv
// Shared types and constants for the AD frame packer.
// Optional trailing checksum word is enabled by defining AD_FRAME_CHECKSUM_EN.
package ad_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_SYNC,
    HDR_CNT,
    HDR_LEN,
    PAYLOAD,
    CSUM
  } state_t;

  localparam logic [15:0] SYNC_DEFAULT = 16'hAA55;
  localparam int          HDR_WORDS    = 3;

  // Total words written downstream for one frame of len payload words.
  function automatic int frame_words(input int len);
`ifdef AD_FRAME_CHECKSUM_EN
    return len + HDR_WORDS + 1;
`else
    return len + HDR_WORDS;
`endif
  endfunction

endpackage

// File: rtl/frame_csum.sv
// 16-bit wrapping sum of payload words; clr has priority over add_en.
module frame_csum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add_en,
  input  logic [15:0] din,
  output logic [15:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sum <= '0;
    else if (clr)    sum <= '0;
    else if (add_en) sum <= sum + din;
  end

endmodule

// File: rtl/ad_frame_packer.sv
// Packs AD FIFO words into SYNC/CNT/LEN/payload[/CSUM] frames for a USB FIFO.
// Define AD_FRAME_CHECKSUM_EN to append the payload checksum word.
module ad_frame_packer
  import ad_frame_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_DEFAULT
) (
  input  logic        i_clk_sys,
  input  logic        i_rst,
  input  logic        i_st,
  input  logic [15:0] i_recv_count,
  input  logic [15:0] i_data,
  input  logic        i_data_valid,
  output logic        o_rd,
  output logic        o_wr,
  output logic [15:0] o_wr_data,
  input  logic        i_full,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic        o_overrun
);

  state_t      state, state_nx;
  logic [15:0] len, pcnt;
  logic        start, last, wr_nx;
  logic [15:0] wdata_nx;

`ifdef AD_FRAME_CHECKSUM_EN
  logic [15:0] csum_sum;

  frame_csum u_csum (
    .clk    (i_clk_sys),
    .rst    (i_rst),
    .clr    (start),
    .add_en (o_rd),
    .din    (i_data),
    .sum    (csum_sum)
  );
`endif

  assign o_busy    = (state != IDLE);
  assign o_overrun = i_st && o_busy;

  always_comb begin
    state_nx = state;
    wr_nx    = 1'b0;
    wdata_nx = '0;
    o_rd     = 1'b0;
    start    = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: if (i_st) begin
        start    = 1'b1;
        state_nx = HDR_SYNC;
      end
      HDR_SYNC: if (!i_full) begin
        wr_nx    = 1'b1;
        wdata_nx = SYNC_WORD;
        state_nx = HDR_CNT;
      end
      HDR_CNT: if (!i_full) begin
        wr_nx    = 1'b1;
        wdata_nx = o_frame_cnt;
        state_nx = HDR_LEN;
      end
      HDR_LEN: if (!i_full) begin
        wr_nx    = 1'b1;
        wdata_nx = len;
        if (len != '0) state_nx = PAYLOAD;
        else begin
`ifdef AD_FRAME_CHECKSUM_EN
          state_nx = CSUM;
`else
          state_nx = IDLE;
          last     = 1'b1;
`endif
        end
      end
      // Pop only when a word can actually be forwarded this cycle.
      PAYLOAD: if (i_data_valid && !i_full) begin
        o_rd     = 1'b1;
        wr_nx    = 1'b1;
        wdata_nx = i_data;
        if (pcnt == len - 16'd1) begin
`ifdef AD_FRAME_CHECKSUM_EN
          state_nx = CSUM;
`else
          state_nx = IDLE;
          last     = 1'b1;
`endif
        end
      end
      CSUM: begin
`ifdef AD_FRAME_CHECKSUM_EN
        if (!i_full) begin
          wr_nx    = 1'b1;
          wdata_nx = csum_sum;
          state_nx = IDLE;
          last     = 1'b1;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      len         <= '0;
      pcnt        <= '0;
      o_wr        <= 1'b0;
      o_wr_data   <= '0;
      o_frame_cnt <= '0;
    end else begin
      state     <= state_nx;
      o_wr      <= wr_nx;
      o_wr_data <= wdata_nx;
      if (start) begin
        len  <= i_recv_count;
        pcnt <= '0;
      end else if (o_rd) begin
        pcnt <= pcnt + 16'd1;
      end
      if (last) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ad_frame_packer.sv
// Scoreboard bench for ad_frame_packer: table of frames plus reset, overrun and wrap sequences.
module tb_ad_frame_packer;
  import ad_frame_pkg::*;

  localparam logic [15:0] SYNC = 16'hAA55;
`ifdef AD_FRAME_CHECKSUM_EN
  localparam int CS_WORDS = 1;
`else
  localparam int CS_WORDS = 0;
`endif

  logic        i_clk_sys = 1'b0;
  logic        i_rst, i_st, i_data_valid, i_full;
  logic [15:0] i_recv_count, i_data;
  logic        o_rd, o_wr, o_busy, o_overrun;
  logic [15:0] o_wr_data, o_frame_cnt;

  ad_frame_packer dut (
    .i_clk_sys    (i_clk_sys),
    .i_rst        (i_rst),
    .i_st         (i_st),
    .i_recv_count (i_recv_count),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_rd         (o_rd),
    .o_wr         (o_wr),
    .o_wr_data    (o_wr_data),
    .i_full       (i_full),
    .o_busy       (o_busy),
    .o_frame_cnt  (o_frame_cnt),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk_sys = ~i_clk_sys;

  typedef struct {
    logic [15:0] len;
    logic [15:0] d0;
    logic [15:0] step;
    bit          stall;
    int          st_at;
    logic [15:0] csum;
  } vec_t;

  int          checks = 0, fails = 0;
  int          wr_n = 0, rd_n = 0, ovr_n = 0;
  bit          sb_en = 1'b1;
  logic [15:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  vec_t        tbl[7];

  task automatic report(input string name, input logic [15:0] act, input logic [15:0] exp);
    fails++;
    if (fails <= 20) $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) report(name, act, exp);
  endtask

  // Output monitor: every write is popped against the scoreboard.
  always @(negedge i_clk_sys) begin
    if (o_overrun) ovr_n++;
    if (sb_en && o_rd) begin
      rd_n++;
      chk("rd_gating", {15'b0, i_data_valid && !i_full && o_busy}, 16'h1);
    end
    if (sb_en && o_wr) begin
      wr_n++;
      checks++;
      if (exp_q.size() == 0) report("unexpected_wr", o_wr_data, 16'hxxxx);
      else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (o_wr_data !== e) report("wr_data", o_wr_data, e);
      end
    end
  end

  task automatic run_frame(input vec_t v);
    logic [15:0] fifo[$];
    logic [15:0] w;
    int          rd0, wr0, ovr0;
    bit          done;
    done = 1'b0;
    rd0 = rd_n; wr0 = wr_n; ovr0 = ovr_n;
    exp_q.push_back(SYNC);
    exp_q.push_back(exp_cnt);
    exp_q.push_back(v.len);
    for (int k = 0; k < int'(v.len); k++) begin
      w = v.d0 + 16'(k) * v.step;
      fifo.push_back(w);
      exp_q.push_back(w);
    end
    if (CS_WORDS == 1) exp_q.push_back(v.csum);
    i_st = 1'b1; i_recv_count = v.len; i_full = 1'b0; i_data_valid = 1'b0;
    @(posedge i_clk_sys) #1;
    i_st = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      i_full       = v.stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      i_data_valid = (fifo.size() > 0) && (v.stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      i_data       = (fifo.size() > 0) ? fifo[0] : 16'h0;
      i_st         = (cyc == v.st_at);
      i_recv_count = 16'h0009;
      @(negedge i_clk_sys);
      if (o_rd && fifo.size() > 0) void'(fifo.pop_front());
      if (cyc == v.st_at) chk("overrun_pulse", {15'b0, o_overrun}, 16'h1);
      @(posedge i_clk_sys) #1;
      i_st = 1'b0;
      done = (exp_q.size() == 0) && !o_busy;
    end
    i_data_valid = 1'b0; i_full = 1'b0;
    if (!done) begin
      report("frame_timeout", 16'(exp_q.size()), 16'h0);
      exp_q.delete();
    end
    exp_cnt++;
    chk("frame_cnt", o_frame_cnt, exp_cnt);
    chk("rd_count", 16'(rd_n - rd0), v.len);
    chk("wr_count", 16'(wr_n - wr0), 16'(frame_words(int'(v.len))));
    chk("overrun_count", 16'(ovr_n - ovr0), (v.st_at >= 0) ? 16'h1 : 16'h0);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    //          len     d0       step     stall st_at csum
    tbl[0] = '{16'd4, 16'h0001, 16'h0001, 1'b0, -1, 16'h000A};
    tbl[1] = '{16'd0, 16'h0000, 16'h0000, 1'b0, -1, 16'h0000};
    tbl[2] = '{16'd3, 16'hFFFF, 16'h0000, 1'b1, -1, 16'hFFFD};
    tbl[3] = '{16'd5, 16'h8000, 16'h8000, 1'b1, -1, 16'h8000};
    tbl[4] = '{16'd2, 16'h1234, 16'h1111, 1'b0, -1, 16'h3579};
    tbl[5] = '{16'd1, 16'hABCD, 16'h0000, 1'b1, -1, 16'hABCD};
    tbl[6] = '{16'd4, 16'h0010, 16'h0010, 1'b0,  4, 16'h00A0};

    i_rst = 1'b1; i_st = 1'b0; i_recv_count = '0; i_data = '0;
    i_data_valid = 1'b0; i_full = 1'b0;
    repeat (2) @(posedge i_clk_sys);
    #1;
    chk("rst_wr", {15'b0, o_wr}, 16'h0);
    chk("rst_rd", {15'b0, o_rd}, 16'h0);
    chk("rst_busy", {15'b0, o_busy}, 16'h0);
    chk("rst_overrun", {15'b0, o_overrun}, 16'h0);
    chk("rst_wr_data", o_wr_data, 16'h0);
    chk("rst_frame_cnt", o_frame_cnt, 16'h0);
    i_rst = 1'b0;
    @(posedge i_clk_sys) #1;

    foreach (tbl[i]) run_frame(tbl[i]);

    // After the overrun frame nothing else may start.
    repeat (8) @(posedge i_clk_sys);
    #1;
    chk("no_second_frame_busy", {15'b0, o_busy}, 16'h0);
    chk("no_second_frame_cnt", o_frame_cnt, exp_cnt);

    // Reset in the middle of a payload.
    sb_en = 1'b0;
    i_st = 1'b1; i_recv_count = 16'd6; i_data = 16'h0077; i_data_valid = 1'b1;
    @(posedge i_clk_sys) #1;
    i_st = 1'b0;
    repeat (5) @(posedge i_clk_sys) #1;
    chk("pre_rst_busy", {15'b0, o_busy}, 16'h1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_wr", {15'b0, o_wr}, 16'h0);
    chk("mid_rst_rd", {15'b0, o_rd}, 16'h0);
    chk("mid_rst_busy", {15'b0, o_busy}, 16'h0);
    chk("mid_rst_wr_data", o_wr_data, 16'h0);
    chk("mid_rst_frame_cnt", o_frame_cnt, 16'h0);
    chk("mid_rst_overrun", {15'b0, o_overrun}, 16'h0);
    @(posedge i_clk_sys) #1;
    i_rst = 1'b0; i_data_valid = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    sb_en = 1'b1;
    @(posedge i_clk_sys) #1;
    run_frame('{16'd4, 16'h0001, 16'h0001, 1'b0, -1, 16'h000A});

    // Drive the counter up to FFFF with back-to-back len=0 frames.
    rd0 = rd_n;
    for (int f = 0; f < 65534; f++) begin
      exp_q.push_back(SYNC);
      exp_q.push_back(exp_cnt);
      exp_q.push_back(16'h0000);
      if (CS_WORDS == 1) exp_q.push_back(16'h0000);
      exp_cnt++;
      i_st = 1'b1; i_recv_count = 16'h0000;
      @(posedge i_clk_sys) #1;
      i_st = 1'b0;
      repeat (HDR_WORDS + CS_WORDS) @(posedge i_clk_sys) #1;
    end
    repeat (2) @(posedge i_clk_sys) #1;
    chk("preload_cnt", o_frame_cnt, 16'hFFFF);
    chk("preload_drained", 16'(exp_q.size()), 16'h0);
    chk("preload_no_rd", 16'(rd_n - rd0), 16'h0);
    run_frame('{16'd2, 16'h0005, 16'h0001, 1'b0, -1, 16'h000B});
    chk("wrap_cnt", o_frame_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ad_frame_packer.md
AD_FRAME_PACKER -- requirements
Module: ad_frame_packer

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hAA55: first header word of every frame.
REQ-002 SHALL have port i_clk_sys, input, 1: single system clock (100 MHz domain); all logic on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port i_st, input, 1: one-cycle frame start pulse, synchronous to i_clk_sys.
REQ-005 SHALL have port i_recv_count, input, 16: payload word count, sampled on accepted i_st.
REQ-006 SHALL have port i_data, input, 16: dual-sample word from the upstream show-ahead AD FIFO.
REQ-007 SHALL have port i_data_valid, input, 1: upstream FIFO not empty; i_data is valid.
REQ-008 SHALL have port o_rd, output, 1: upstream pop strobe.
REQ-009 SHALL have port o_wr, output, 1: downstream (USB FIFO) write strobe.
REQ-010 SHALL have port o_wr_data, output, 16: downstream write word.
REQ-011 SHALL have port i_full, input, 1: downstream almost-full; at least one free slot remains when asserted.
REQ-012 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port o_frame_cnt, output, 16: number of completed frames.
REQ-014 SHALL have port o_overrun, output, 1: one-cycle pulse when i_st is dropped.

Function
REQ-015 SHALL implement FSM IDLE -> HDR_SYNC -> HDR_CNT -> HDR_LEN -> PAYLOAD -> CSUM -> IDLE.
REQ-016 SHALL leave IDLE only on i_st=1, latching i_recv_count into len and clearing the checksum accumulator.
REQ-017 SHALL emit, one word per state, SYNC_WORD, o_frame_cnt and len in the header states, each only in a cycle with i_full=0; otherwise hold state.
REQ-018 SHALL, in PAYLOAD, pop and forward one word per cycle only when i_data_valid=1 and i_full=0; o_rd is combinational in that cycle.
REQ-019 SHALL register o_wr/o_wr_data: the word decided in cycle N appears at the output in cycle N+1 (latency 1).
REQ-020 SHALL leave PAYLOAD after exactly len words; len=0 skips PAYLOAD directly to CSUM.
REQ-021 SHALL compute the checksum as the 16-bit sum modulo 2^16 of payload words; len=0 yields 16'h0000.
REQ-022 SHALL increment o_frame_cnt on the last word of the frame, wrapping 16'hFFFF -> 16'h0000.
REQ-023 SHALL ignore i_st while o_busy=1, pulse o_overrun for that cycle, and leave the frame in progress unaffected.
REQ-024 SHALL never assert o_rd outside PAYLOAD, and never assert o_rd when i_data_valid=0.
REQ-025 SHALL accept i_st in the cycle the FSM returns to IDLE only on the following cycle (no back-to-back in the same cycle).

Reset
REQ-026 SHALL, on i_rst=1 at any time (including mid-frame), force state IDLE and set o_rd=0, o_wr=0, o_wr_data=0, o_busy=0, o_frame_cnt=0, o_overrun=0, and clear len and checksum.

Configuration
REQ-027 SHALL, with macro AD_FRAME_CHECKSUM_EN defined, include CSUM and the accumulator as above.
REQ-028 SHALL, without AD_FRAME_CHECKSUM_EN, omit CSUM and the accumulator and finish the frame from PAYLOAD (or HDR_LEN when len=0) directly to IDLE; frames are then len+3 words.

Structure
REQ-029 SHALL place the state enumeration, default SYNC_WORD constant and header length (3) in shared package ad_frame_pkg.
REQ-030 SHALL implement the checksum accumulator as sub-module frame_csum (clear, add-enable, 16-bit data in, 16-bit sum out).

Verification
REQ-031 SHALL cover: len=4, data 1,2,3,4, i_full=0 -> o_wr words AA55,0000,0004,0001,0002,0003,0004,000A; o_frame_cnt=1.
REQ-032 SHALL cover: len=0 -> AA55,cnt,0000,0000 with checksum enabled; AA55,cnt,0000 without; no o_rd pulses.
REQ-033 SHALL cover: i_data_valid toggling and i_full asserted mid-payload -> no o_rd while either blocks; the word sequence is unchanged.
REQ-034 SHALL cover: i_st during PAYLOAD -> single o_overrun pulse; current frame completes intact; no second frame.
REQ-035 SHALL cover: i_rst pulsed mid-PAYLOAD -> all outputs 0 and IDLE; the next i_st starts a frame with counter 0000.
REQ-036 SHALL cover: preload o_frame_cnt to FFFF via 65535 len=0 frames -> next completed frame reads cnt FFFF in its header, then o_frame_cnt=0000.
